// File: rtl/usb_rx_pkg.sv
// Shared USB receive-path types and default sizes.
package usb_rx_pkg;

  localparam int USB_BYTE_W      = 8;
  localparam int USB_STUFF_LIMIT = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    SKIP   = 2'd2
  } unstuff_state_t;

endpackage

// File: rtl/rx_shift_reg.sv
// LSB-first shift register: new bits enter at the MSB, with synchronous clear.
module rx_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              d_in,
  output logic [DATA_W-1:0] q
);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {d_in, q[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/usb_rx_unstuff_shift.sv
// USB RX bit-unstuffer and deserializer: drops stuff bits, assembles LSB-first bytes.
module usb_rx_unstuff_shift
  import usb_rx_pkg::*;
#(
  parameter int DATA_W      = USB_BYTE_W,
  parameter int STUFF_LIMIT = USB_STUFF_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rcving,
  input  logic              shift_enable,
  input  logic              d_orig,
  input  logic              eop,
  output logic [DATA_W-1:0] rx_data,
  output logic              byte_ready,
  output logic              stuff_err
);

  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

  unstuff_state_t     state, state_next;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_next;
  logic [ONES_W-1:0]  ones_cnt, ones_cnt_next, ones_inc;
  logic [DATA_W-1:0]  shreg;
  logic               shift_do, clr_part, byte_done, stuff_err_next;

  assign ones_inc = ones_cnt + ONES_W'(1);

  rx_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_part),
    .shift_en (shift_do),
    .d_in     (d_orig),
    .q        (shreg)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    ones_cnt_next  = ones_cnt;
    shift_do       = 1'b0;
    clr_part       = 1'b0;
    byte_done      = 1'b0;
    stuff_err_next = 1'b0;

    if (!rcving || eop) begin
      // Leaving the receive window or end of packet drops any partial byte.
      state_next    = rcving ? ACTIVE : IDLE;
      bit_cnt_next  = '0;
      ones_cnt_next = '0;
      clr_part      = 1'b1;
    end else begin
      unique case (state)
        IDLE: state_next = ACTIVE;
        ACTIVE: begin
          if (shift_enable) begin
            shift_do  = 1'b1;
            byte_done = (bit_cnt == CNT_W'(DATA_W - 1));
            bit_cnt_next = byte_done ? '0 : bit_cnt + CNT_W'(1);
            if (d_orig) begin
              ones_cnt_next = ones_inc;
              if (ones_inc == ONES_W'(STUFF_LIMIT)) state_next = SKIP;
            end else begin
              ones_cnt_next = '0;
            end
          end
        end
        SKIP: begin
          if (shift_enable) begin
            ones_cnt_next  = '0;
            stuff_err_next = d_orig;
            state_next     = ACTIVE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      ones_cnt   <= '0;
      rx_data    <= '0;
      byte_ready <= 1'b0;
      stuff_err  <= 1'b0;
    end else begin
      bit_cnt    <= bit_cnt_next;
      ones_cnt   <= ones_cnt_next;
      byte_ready <= byte_done;
      stuff_err  <= stuff_err_next;
      // Capture the word as it will look after this final shift.
      if (byte_done) rx_data <= DATA_W'({d_orig, shreg} >> 1);
    end
  end

endmodule

// File: tb/tb_usb_rx_unstuff_shift.sv
// Randomized scoreboard bench for usb_rx_unstuff_shift against a queue-based reference model.
module tb_usb_rx_unstuff_shift;

  logic       clk = 1'b0;
  logic       rst, rcving, shift_enable, d_orig, eop;
  logic [7:0] rx_data;
  logic       byte_ready, stuff_err;

  usb_rx_unstuff_shift dut (
    .clk          (clk),
    .rst          (rst),
    .rcving       (rcving),
    .shift_enable (shift_enable),
    .d_orig       (d_orig),
    .eop          (eop),
    .rx_data      (rx_data),
    .byte_ready   (byte_ready),
    .stuff_err    (stuff_err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         is_byte;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];

  // Reference model: received data bits, current run of ones, stuff slot pending.
  bit m_bits[$];
  int m_run;
  bit m_skip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic push_ev(input bit is_byte, input logic [7:0] data);
    ev_t e;
    e.is_byte = is_byte;
    e.data    = data;
    e.cyc     = cycle + 1;
    exp_q.push_back(e);
  endtask

  task automatic model_clear();
    m_bits.delete();
    m_run  = 0;
    m_skip = 1'b0;
  endtask

  task automatic model_step(input bit d, input bit e);
    logic [7:0] w;
    if (e) begin
      model_clear();
    end else if (m_skip) begin
      m_skip = 1'b0;
      m_run  = 0;
      if (d) push_ev(1'b0, 8'h00);
    end else begin
      m_bits.push_back(d);
      m_run = d ? m_run + 1 : 0;
      if (m_run == 6) m_skip = 1'b1;
      if (m_bits.size() == 8) begin
        w = '0;
        for (int i = 0; i < 8; i++) w[i] = m_bits[i];
        push_ev(1'b1, w);
        m_bits.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      d_orig = 1'($urandom);
    end
  endtask

  task automatic strobe(input bit d, input bit e);
    shift_enable = 1'b1;
    d_orig       = d;
    eop          = e;
    model_step(d, e);
    @(posedge clk); #1;
    shift_enable = 1'b0;
    eop          = 1'b0;
    d_orig       = 1'($urandom);
  endtask

  task automatic eop_pulse();
    eop = 1'b1;
    model_clear();
    @(posedge clk); #1;
    eop = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (m_skip) strobe(1'b0, 1'b0);
      strobe(b[i], 1'b0);
      idle(int'($urandom_range(0, 1)));
    end
  endtask

  task automatic bounce_rcving();
    rcving = 1'b0;
    model_clear();
    idle(1);
    rcving = 1'b1;
    idle(1);
  endtask

  // Monitor: every pulse must match the oldest expected event, in the expected cycle.
  always @(negedge clk) begin
    ev_t e;
    if (rst === 1'b0) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cycle) begin
        check("missed_pulse_cycle", cycle, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (byte_ready === 1'b1 || stuff_err === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {byte_ready, stuff_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {byte_ready, stuff_err}, e.is_byte ? 32'd2 : 32'd1);
          check("pulse_cycle", cycle, e.cyc);
          if (e.is_byte) check("rx_data", rx_data, e.data);
        end
      end
    end
  end

  initial begin
    logic [7:0] rb;
    logic [7:0] a5_bits;
    rst = 1'b1;
    model_clear();

    // 1: reset with random inputs present
    repeat (2) begin
      rcving       = 1'($urandom);
      shift_enable = 1'($urandom);
      d_orig       = 1'($urandom);
      eop          = 1'($urandom);
      @(negedge clk);
      check("reset_rx_data", rx_data, 32'h00);
      check("reset_byte_ready", byte_ready, 32'd0);
      check("reset_stuff_err", stuff_err, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; rcving = 1'b0; shift_enable = 1'b0; eop = 1'b0;
    idle(1);
    rcving = 1'b1;
    idle(1);

    // 2: 0xA5, LSB first, then hold
    a5_bits = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      strobe(a5_bits[i], 1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);
    check("hold_a5", rx_data, 32'hA5);
    check("pulse_gone", byte_ready, 32'd0);

    // 3: stuff zero after six ones is dropped
    eop_pulse();
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    idle(1);
    check("stuffed_ff", rx_data, 32'hFF);

    // 4: a one in the stuff slot raises stuff_err and is still dropped
    eop_pulse();
    strobe(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b0);
    idle(2);
    check("stuff_err_byte", rx_data, 32'h7E);

    // 5: eop on the 5th strobe drops the partial byte
    eop_pulse();
    for (int i = 0; i < 4; i++) strobe(1'($urandom), 1'b0);
    strobe(1'b1, 1'b1);
    rb = 8'($urandom);
    send_byte(rb);
    idle(1);
    check("fresh_after_eop", rx_data, {24'd0, rb});

    // 6: rcving drop mid-byte, then 0x3C
    eop_pulse();
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b0);
    bounce_rcving();
    send_byte(8'h3C);
    idle(1);
    check("after_rcving_drop", rx_data, 32'h3C);

    // Random traffic with stuffing, violations, eop and window drops
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        eop_pulse();
      end else if (r < 5) begin
        bounce_rcving();
      end else if (r < 8) begin
        strobe(1'($urandom), 1'b1);
      end else if (m_skip) begin
        strobe(($urandom_range(0, 3) == 0), 1'b0);
      end else begin
        strobe(($urandom_range(0, 3) != 0), 1'b0);
      end
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
